// File: rtl/exec_result_stage_if.sv
// Handshake/payload bundle between the function unit, the execute result
// stage and the memory stage. Also carries the opcode encodings shared by
// the stage and anything that drives it.

`ifndef EXEC_OPCODES_DEFINED
`define EXEC_OPCODES_DEFINED
`define ADD 7'h01
`define SUB 7'h02
`define ADI 7'h03
`define SBI 7'h04
`define AIU 7'h05
`define SIU 7'h06
`define SLT 7'h07
`define AND 7'h08
`define BZ  7'h10
`define BNZ 7'h11
`endif

interface exec_result_stage_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_opcode;
  logic [REG_AW-1:0] in_dest;
  logic              in_wen;
  logic [DATA_W-1:0] in_result;
  logic              in_carry;
  logic              in_overflow;
  logic              in_negative;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [OP_W-1:0]   out_opcode;
  logic [REG_AW-1:0] out_dest;
  logic              out_wen;
  logic [DATA_W-1:0] out_result;
  logic [3:0]        out_flags;

  // Upstream producer / downstream consumer side (drives the stage)
  modport master (
    output in_valid, in_opcode, in_dest, in_wen, in_result,
           in_carry, in_overflow, in_negative, in_zero, out_ready,
    input  in_ready, out_valid, out_opcode, out_dest, out_wen,
           out_result, out_flags
  );

  // The stage itself
  modport slave (
    input  in_valid, in_opcode, in_dest, in_wen, in_result,
           in_carry, in_overflow, in_negative, in_zero, out_ready,
    output in_ready, out_valid, out_opcode, out_dest, out_wen,
           out_result, out_flags
  );
endinterface

// File: rtl/exec_result_stage.sv
// Execute-to-memory stage: 2-entry skid buffer holding the FU result, flags
// and instruction fields. Finalises SLT, tracks architectural status flags
// and resolves BZ/BNZ into a one-cycle branch_taken pulse. Flags are {V,C,N,Z}.

module exec_result_stage #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 7,
  parameter int REG_AW = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  exec_result_stage_if.slave  bus,
  input  logic                flush,
  output logic [3:0]          status_flags,
  output logic                branch_taken,
  output logic [1:0]          occupancy
);

  typedef struct packed {
    logic [OP_W-1:0]   opcode;
    logic [REG_AW-1:0] dest;
    logic              wen;
    logic [DATA_W-1:0] result;
    logic [3:0]        flags;
  } entry_t;

  // head_q is always the entry presented downstream; tail_q only matters at occupancy 2
  entry_t     head_q, head_d;
  entry_t     tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       in_ready_q, in_ready_d;
  logic [3:0] status_q, status_d;
  logic       branch_q, branch_d;

  logic   push;
  logic   pop;
  entry_t new_e;

  // SLT turns the FU compare into a 0/1 result; Z must then describe that value
  function automatic entry_t capture(
    input logic [OP_W-1:0]   op,
    input logic [REG_AW-1:0] dest,
    input logic              wen,
    input logic [DATA_W-1:0] res,
    input logic              c,
    input logic              v,
    input logic              n,
    input logic              z
  );
    entry_t e;
    logic   lt;
    e.opcode = op;
    e.dest   = dest;
    e.wen    = wen;
    if (op == `SLT) begin
      lt       = n ^ v;
      e.result = {{(DATA_W-1){1'b0}}, lt};
      e.flags  = {v, c, n, ~lt};
    end else begin
      e.result = res;
      e.flags  = {v, c, n, z};
    end
    return e;
  endfunction

  function automatic logic sets_flags(input logic [OP_W-1:0] op);
    return (op == `ADD) || (op == `SUB) || (op == `ADI) || (op == `SBI) ||
           (op == `AIU) || (op == `SIU) || (op == `SLT);
  endfunction

  function automatic logic is_branch(input logic [OP_W-1:0] op);
    return (op == `BZ) || (op == `BNZ);
  endfunction

  // Next-state for buffer contents, occupancy, status flags and branch pulse
  always_comb begin
    push  = bus.in_valid & in_ready_q & ~flush;
    pop   = (occ_q != 2'd0) & bus.out_ready;
    new_e = capture(bus.in_opcode, bus.in_dest, bus.in_wen, bus.in_result,
                    bus.in_carry, bus.in_overflow, bus.in_negative, bus.in_zero);

    head_d   = head_q;
    tail_d   = tail_q;
    occ_d    = occ_q;
    status_d = status_q;
    branch_d = pop & is_branch(head_q.opcode) & head_q.result[0];

    // A pop completes even in a flush cycle, so its side effects still land
    if (pop && sets_flags(head_q.opcode)) begin
      status_d = head_q.flags;
    end

    if (flush) begin
      occ_d  = 2'd0;
      head_d = '0;
      tail_d = '0;
    end else begin
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_d = new_e;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = new_e;
          end else if (push) begin
            tail_d = new_e;
            occ_d  = 2'd2;
          end else if (pop) begin
            occ_d  = 2'd0;
          end
        end
        default: begin
          // Full: in_ready is low so only a pop can happen
          if (pop) begin
            head_d = tail_q;
            occ_d  = 2'd1;
          end
        end
      endcase
    end

    // Registered ready derived from next occupancy keeps out_ready off the in_ready path
    in_ready_d = (occ_d != 2'd2);
  end

  // State registers; reset empties the buffer and clears every payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      in_ready_q <= 1'b1;
      status_q   <= 4'd0;
      branch_q   <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      in_ready_q <= in_ready_d;
      status_q   <= status_d;
      branch_q   <= branch_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (occ_q != 2'd0);
  assign bus.out_opcode = head_q.opcode;
  assign bus.out_dest   = head_q.dest;
  assign bus.out_wen    = head_q.wen;
  assign bus.out_result = head_q.result;
  assign bus.out_flags  = head_q.flags;
  assign status_flags   = status_q;
  assign branch_taken   = branch_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_exec_result_stage.sv
// Bench for exec_result_stage: queue-based reference model checked every
// cycle, plus directed vectors with literal expectations.

`ifndef EXEC_OPCODES_DEFINED
`define EXEC_OPCODES_DEFINED
`define ADD 7'h01
`define SUB 7'h02
`define ADI 7'h03
`define SBI 7'h04
`define AIU 7'h05
`define SIU 7'h06
`define SLT 7'h07
`define AND 7'h08
`define BZ  7'h10
`define BNZ 7'h11
`endif

module tb_exec_result_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] status_flags;
  logic       branch_taken;
  logic [1:0] occupancy;

  int checks = 0;
  int failures = 0;

  exec_result_stage_if #(.DATA_W(32), .OP_W(7), .REG_AW(5)) bus ();

  exec_result_stage #(.DATA_W(32), .OP_W(7), .REG_AW(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .flush        (flush),
    .status_flags (status_flags),
    .branch_taken (branch_taken),
    .occupancy    (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  dest;
    logic        wen;
    logic [31:0] result;
    logic [3:0]  flags;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_status;
  logic       m_branch;
  logic       m_pop;
  logic       m_push;
  ent_t       m_head;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic ent_t model_capture(input logic [6:0] op, input logic [4:0] dest,
                                         input logic wen, input logic [31:0] res,
                                         input logic c, input logic v, input logic n,
                                         input logic z);
    ent_t e;
    int   slt_val;
    e.op   = op;
    e.dest = dest;
    e.wen  = wen;
    if (op == `SLT) begin
      slt_val  = (n != v) ? 1 : 0;
      e.result = 32'(slt_val);
      e.flags  = {v, c, n, (slt_val == 0)};
    end else begin
      e.result = res;
      e.flags  = {v, c, n, z};
    end
    return e;
  endfunction

  // Reference model: FIFO of at most two entries
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_status = 4'd0;
      m_branch = 1'b0;
    end else begin
      m_pop    = (mq.size() > 0) && bus.out_ready;
      m_push   = bus.in_valid && (mq.size() < 2) && !flush;
      m_branch = 1'b0;
      if (m_pop) begin
        m_head = mq.pop_front();
        if (m_head.op == `BZ || m_head.op == `BNZ) m_branch = m_head.result[0];
        if (m_head.op inside {`ADD, `SUB, `ADI, `SBI, `AIU, `SIU, `SLT}) m_status = m_head.flags;
      end
      if (flush) mq.delete();
      else if (m_push)
        mq.push_back(model_capture(bus.in_opcode, bus.in_dest, bus.in_wen, bus.in_result,
                                   bus.in_carry, bus.in_overflow, bus.in_negative, bus.in_zero));
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("in_ready", 64'(bus.in_ready), 64'(mq.size() < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(mq.size() > 0));
    chk("status_flags", 64'(status_flags), 64'(m_status));
    chk("branch_taken", 64'(branch_taken), 64'(m_branch));
    if (mq.size() > 0)
      chk("head_payload",
          64'({bus.out_opcode, bus.out_dest, bus.out_wen, bus.out_result, bus.out_flags}),
          64'({mq[0].op, mq[0].dest, mq[0].wen, mq[0].result, mq[0].flags}));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // flags argument is {V,C,N,Z}
  task automatic setin(input logic v, input logic [6:0] op, input logic [31:0] res,
                       input logic [3:0] fl);
    bus.in_valid    = v;
    bus.in_opcode   = op;
    bus.in_dest     = res[4:0];
    bus.in_wen      = 1'b1;
    bus.in_result   = res;
    bus.in_overflow = fl[3];
    bus.in_carry    = fl[2];
    bus.in_negative = fl[1];
    bus.in_zero     = fl[0];
  endtask

  task automatic push1(input logic [6:0] op, input logic [31:0] res, input logic [3:0] fl);
    setin(1'b1, op, res, fl);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    setin(1'b0, 7'h00, 32'h0, 4'h0);
    #12;
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_result", 64'(bus.out_result), 64'd0);
    chk("rst_status", 64'(status_flags), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single ADD through an idle stage
    bus.out_ready = 1'b1;
    push1(`ADD, 32'h0000_0005, 4'b0000);
    chk("add_out_valid", 64'(bus.out_valid), 64'd1);
    chk("add_out_result", 64'(bus.out_result), 64'd5);
    tick();
    chk("add_status", 64'(status_flags), 64'd0);
    chk("add_drained", 64'(occupancy), 64'd0);

    // Fill with out_ready low; third push must be refused
    bus.out_ready = 1'b0;
    setin(1'b1, `ADD, 32'h0000_000A, 4'b0101);
    tick();
    chk("fill_occ1", 64'(occupancy), 64'd1);
    setin(1'b1, `AND, 32'h0000_000B, 4'b1111);
    tick();
    chk("fill_occ2", 64'(occupancy), 64'd2);
    chk("fill_in_ready", 64'(bus.in_ready), 64'd0);
    setin(1'b1, `ADD, 32'h0000_000C, 4'b0010);
    tick();
    chk("fill_occ_third", 64'(occupancy), 64'd2);
    bus.in_valid  = 1'b0;
    chk("order_head_a", 64'(bus.out_result), 64'h0A);
    bus.out_ready = 1'b1;
    tick();
    chk("order_head_b", 64'(bus.out_result), 64'h0B);
    chk("order_status_a", 64'(status_flags), 64'h5);
    tick();
    chk("order_drained", 64'(occupancy), 64'd0);
    chk("and_keeps_status", 64'(status_flags), 64'h5);

    // SLT finalisation: N=1,V=0 -> result 1, Z=0
    push1(`SLT, 32'hFFFF_FFFE, 4'b0110);
    chk("slt_result", 64'(bus.out_result), 64'd1);
    chk("slt_flags", 64'(bus.out_flags), 64'h6);
    tick();
    chk("slt_status", 64'(status_flags), 64'h6);

    // BZ taken pulse, BNZ not taken
    push1(`BZ, 32'h0000_0001, 4'b0000);
    tick();
    chk("bz_pulse", 64'(branch_taken), 64'd1);
    tick();
    chk("bz_pulse_end", 64'(branch_taken), 64'd0);
    push1(`BNZ, 32'h0000_0000, 4'b0001);
    tick();
    chk("bnz_no_pulse", 64'(branch_taken), 64'd0);
    tick();

    // Back-to-back throughput with out_ready high
    for (int i = 0; i < 4; i++) begin
      setin(1'b1, `SUB, 32'(32'h100 + i), 4'(i));
      tick();
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    bus.in_valid = 1'b0;
    tick();

    // Flush at occupancy 2 with a concurrent push and a flag-setting pop
    bus.out_ready = 1'b0;
    push1(`SUB, 32'h0000_0011, 4'b1000);
    push1(`ADD, 32'h0000_0022, 4'b0001);
    chk("flush_pre_occ", 64'(occupancy), 64'd2);
    flush         = 1'b1;
    bus.out_ready = 1'b1;
    setin(1'b1, `ADI, 32'h0000_0033, 4'b0011);
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_status", 64'(status_flags), 64'h8);
    tick();
    tick();
    chk("flush_push_lost", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset while full
    bus.out_ready = 1'b0;
    push1(`ADD, 32'h0000_0044, 4'b0100);
    push1(`BZ, 32'h0000_0001, 4'b0000);
    chk("rst_pre_occ", 64'(occupancy), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_status", 64'(status_flags), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_no_branch", 64'(branch_taken), 64'd0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
